// File: rtl/instr_category_decoder.sv
// RV32I instruction category decoder: classifies LOAD / STORE / ARITHMETIC words,
// flags illegal and masked categories, extracts register/immediate fields into a
// one-entry result register, and keeps saturating per-category event counters.
module instr_category_decoder #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [2:0]         type_mask,
  input  logic               cnt_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_cat,
  output logic               out_illegal,
  output logic               out_masked,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [31:0]        out_imm,
  output logic [COUNT_W-1:0] cnt_load,
  output logic [COUNT_W-1:0] cnt_store,
  output logic [COUNT_W-1:0] cnt_arith,
  output logic [COUNT_W-1:0] cnt_illegal,
  output logic [COUNT_W-1:0] cnt_masked
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011
  } opcode_e;

  localparam logic [2:0] CAT_LOAD  = 3'b001;
  localparam logic [2:0] CAT_STORE = 3'b010;
  localparam logic [2:0] CAT_ARITH = 3'b100;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;

  logic [2:0]  d_cat;
  logic        d_illegal;
  logic        d_masked;
  logic [4:0]  d_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [31:0] d_imm;
  logic        accept;

  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};

  assign in_ready = !out_valid || out_ready;
  // Reset blocks acceptance even though in_ready may read 1 during reset.
  assign accept   = in_valid && in_ready && !rst;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

  // Combinational decode of the presented word; fields stay zero unless legal.
  always_comb begin
    d_cat = '0;
    d_rd  = '0;
    d_rs1 = '0;
    d_rs2 = '0;
    d_imm = '0;
    case (in_instr[6:0])
      OPC_LOAD: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          d_cat = CAT_LOAD;
          d_rd  = in_instr[11:7];
          d_rs1 = in_instr[19:15];
          d_imm = imm_i;
        end
      end
      OPC_STORE: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
          d_cat = CAT_STORE;
          d_rs1 = in_instr[19:15];
          d_rs2 = in_instr[24:20];
          d_imm = imm_s;
        end
      end
      OPC_OP: begin
        if ((funct7 == 7'b0000000) ||
            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)))) begin
          d_cat = CAT_ARITH;
          d_rd  = in_instr[11:7];
          d_rs1 = in_instr[19:15];
          d_rs2 = in_instr[24:20];
        end
      end
      OPC_OP_IMM: begin
        if (((funct3 == 3'b001) && (funct7 == 7'b0000000)) ||
            ((funct3 == 3'b101) && ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))) ||
            ((funct3 != 3'b001) && (funct3 != 3'b101))) begin
          d_cat = CAT_ARITH;
          d_rd  = in_instr[11:7];
          d_rs1 = in_instr[19:15];
          d_imm = imm_i;
        end
      end
      default: ;
    endcase
    d_illegal = (d_cat == '0);
    d_masked  = !d_illegal && ((d_cat & type_mask) == '0);
  end

  // One-entry result register; simultaneous drain and accept keeps out_valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_cat     <= '0;
      out_illegal <= 1'b0;
      out_masked  <= 1'b0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_imm     <= '0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_cat     <= d_cat;
      out_illegal <= d_illegal;
      out_masked  <= d_masked;
      out_rd      <= d_rd;
      out_rs1     <= d_rs1;
      out_rs2     <= d_rs2;
      out_imm     <= d_imm;
    end else if (out_valid && out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Saturating statistics counters; clear wins over a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_load    <= '0;
      cnt_store   <= '0;
      cnt_arith   <= '0;
      cnt_illegal <= '0;
      cnt_masked  <= '0;
    end else if (accept) begin
      if (d_cat[0]) cnt_load    <= sat_inc(cnt_load);
      if (d_cat[1]) cnt_store   <= sat_inc(cnt_store);
      if (d_cat[2]) cnt_arith   <= sat_inc(cnt_arith);
      if (d_illegal) cnt_illegal <= sat_inc(cnt_illegal);
      if (d_masked)  cnt_masked  <= sat_inc(cnt_masked);
    end
  end

endmodule

// File: tb/tb_instr_category_decoder.sv
// Self-checking bench for instr_category_decoder: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a reference model.
module tb_instr_category_decoder;

  localparam int unsigned CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_instr = '0;
  logic [2:0]    type_mask = 3'b111;
  logic          cnt_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2:0]    out_cat;
  logic          out_illegal;
  logic          out_masked;
  logic [4:0]    out_rd, out_rs1, out_rs2;
  logic [31:0]   out_imm;
  logic [CW-1:0] cnt_load, cnt_store, cnt_arith, cnt_illegal, cnt_masked;

  instr_category_decoder #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .type_mask(type_mask), .cnt_clr(cnt_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_cat(out_cat),
    .out_illegal(out_illegal), .out_masked(out_masked), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .cnt_load(cnt_load), .cnt_store(cnt_store), .cnt_arith(cnt_arith),
    .cnt_illegal(cnt_illegal), .cnt_masked(cnt_masked)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic [2:0]  cat;
    logic        illegal;
    logic        masked;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } res_t;

  // Reference decode straight from the instruction-set rules.
  function automatic res_t ref_decode(input logic [31:0] w, input logic [2:0] m);
    res_t r;
    logic [6:0] opc;
    int f3, f7;
    bit legal;
    opc = w[6:0];
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    r = '0;
    legal = 1'b0;
    if (opc == 7'h03) begin
      legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
      r.cat = 3'b001; r.rd = w[11:7]; r.rs1 = w[19:15];
      r.imm = 32'($signed(w[31:20]));
    end else if (opc == 7'h23) begin
      legal = (f3 <= 2);
      r.cat = 3'b010; r.rs1 = w[19:15]; r.rs2 = w[24:20];
      r.imm = 32'($signed({w[31:25], w[11:7]}));
    end else if (opc == 7'h33) begin
      legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      r.cat = 3'b100; r.rd = w[11:7]; r.rs1 = w[19:15]; r.rs2 = w[24:20];
    end else if (opc == 7'h13) begin
      if (f3 == 1) legal = (f7 == 0);
      else if (f3 == 5) legal = (f7 == 0 || f7 == 32);
      else legal = 1'b1;
      r.cat = 3'b100; r.rd = w[11:7]; r.rs1 = w[19:15];
      r.imm = 32'($signed(w[31:20]));
    end
    if (!legal) begin
      r = '0;
      r.illegal = 1'b1;
    end else begin
      r.masked = ((r.cat & m) == 3'b000);
    end
    return r;
  endfunction

  // Reference state: held result, valid flag and integer counters.
  bit   m_valid = 1'b0;
  res_t m_res = '0;
  int   mc_load = 0, mc_store = 0, mc_arith = 0, mc_ill = 0, mc_mask = 0;

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  always @(posedge clk) begin
    res_t d;
    bit acc;
    if (rst) begin
      m_valid = 1'b0; m_res = '0;
      mc_load = 0; mc_store = 0; mc_arith = 0; mc_ill = 0; mc_mask = 0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      d = ref_decode(in_instr, type_mask);
      if (cnt_clr) begin
        mc_load = 0; mc_store = 0; mc_arith = 0; mc_ill = 0; mc_mask = 0;
      end else if (acc) begin
        if (d.illegal) mc_ill = sat(mc_ill);
        else if (d.cat == 3'b001) mc_load = sat(mc_load);
        else if (d.cat == 3'b010) mc_store = sat(mc_store);
        else mc_arith = sat(mc_arith);
        if (d.masked) mc_mask = sat(mc_mask);
      end
      if (acc) begin
        m_valid = 1'b1; m_res = d;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 32'(out_valid), 32'(m_valid));
      chk("m_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      if (m_valid) begin
        chk("m_out_cat", 32'(out_cat), 32'(m_res.cat));
        chk("m_out_illegal", 32'(out_illegal), 32'(m_res.illegal));
        chk("m_out_masked", 32'(out_masked), 32'(m_res.masked));
        chk("m_out_rd", 32'(out_rd), 32'(m_res.rd));
        chk("m_out_rs1", 32'(out_rs1), 32'(m_res.rs1));
        chk("m_out_rs2", 32'(out_rs2), 32'(m_res.rs2));
        chk("m_out_imm", out_imm, m_res.imm);
      end
      chk("m_cnt_load", 32'(cnt_load), 32'(mc_load));
      chk("m_cnt_store", 32'(cnt_store), 32'(mc_store));
      chk("m_cnt_arith", 32'(cnt_arith), 32'(mc_arith));
      chk("m_cnt_illegal", 32'(cnt_illegal), 32'(mc_ill));
      chk("m_cnt_masked", 32'(cnt_masked), 32'(mc_mask));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0] opcs [5];
    opcs[0] = 7'h03; opcs[1] = 7'h23; opcs[2] = 7'h33; opcs[3] = 7'h13;
    opcs[4] = 7'($urandom);
    w = $urandom;
    w[6:0] = opcs[$urandom_range(0, 4)];
    case ($urandom_range(0, 2))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_cat", 32'(out_cat), 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_cnt_load", 32'(cnt_load), 0);
    chk("rst_cnt_masked", 32'(cnt_masked), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    // lw x1, 4(x2)
    in_valid = 1'b1; in_instr = 32'h00412083; type_mask = 3'b111; out_ready = 1'b1;
    cyc();
    chk("lw_valid", 32'(out_valid), 1);
    chk("lw_cat", 32'(out_cat), 32'b001);
    chk("lw_rd", 32'(out_rd), 1);
    chk("lw_rs1", 32'(out_rs1), 2);
    chk("lw_imm", out_imm, 4);
    chk("lw_cnt_load", 32'(cnt_load), 1);

    // sw x1, -4(x2) with STORE disallowed
    in_instr = 32'hFE112E23; type_mask = 3'b101;
    cyc();
    chk("sw_cat", 32'(out_cat), 32'b010);
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    chk("sw_masked", 32'(out_masked), 1);
    chk("sw_rd", 32'(out_rd), 0);
    chk("sw_cnt_store", 32'(cnt_store), 1);
    chk("sw_cnt_masked", 32'(cnt_masked), 1);

    // Back-to-back add, sra, ecall
    type_mask = 3'b111;
    in_instr = 32'h002081B3; cyc();
    chk("add_cat", 32'(out_cat), 32'b100);
    chk("add_rd", 32'(out_rd), 3);
    in_instr = 32'h4020D1B3; cyc();
    chk("sra_cat", 32'(out_cat), 32'b100);
    chk("sra_valid", 32'(out_valid), 1);
    in_instr = 32'h00000073; cyc();
    chk("ecall_illegal", 32'(out_illegal), 1);
    chk("ecall_cat", 32'(out_cat), 0);
    chk("ecall_cnt_arith", 32'(cnt_arith), 2);
    chk("ecall_cnt_illegal", 32'(cnt_illegal), 1);

    // Backpressure: addi x5,x0,7 held, then addi x6,x0,10 waits
    in_valid = 1'b0; cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00700293; out_ready = 1'b0;
    cyc();
    in_instr = 32'h00A00313;
    chk("bp_in_ready", 32'(in_ready), 0);
    chk("bp_rd0", 32'(out_rd), 5);
    cyc();
    chk("bp_rd1", 32'(out_rd), 5);
    chk("bp_imm1", out_imm, 7);
    cyc();
    chk("bp_rd2", 32'(out_rd), 5);
    out_ready = 1'b1;
    #1 chk("bp_in_ready_release", 32'(in_ready), 1);
    cyc();
    chk("bp_next_rd", 32'(out_rd), 6);
    chk("bp_next_valid", 32'(out_valid), 1);
    in_valid = 1'b0;
    cyc();
    chk("bp_drained", 32'(out_valid), 0);
    chk("bp_cnt_arith", 32'(cnt_arith), 2);

    // Saturation and clear-with-accept
    cnt_clr = 1'b1; cyc(); cnt_clr = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00412083;
    repeat (5) cyc();
    chk("sat_cnt_load", 32'(cnt_load), 3);
    cnt_clr = 1'b1;
    cyc();
    chk("clr_cnt_load", 32'(cnt_load), 0);
    chk("clr_valid", 32'(out_valid), 1);
    chk("clr_cat", 32'(out_cat), 32'b001);
    cnt_clr = 1'b0; in_valid = 1'b0;
    cyc();

    // Reset while a result is held
    out_ready = 1'b0; in_valid = 1'b1;
    cyc();
    chk("hold_valid", 32'(out_valid), 1);
    chk("hold_cnt_load", 32'(cnt_load), 1);
    rst = 1'b1;
    cyc();
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_cnt_load", 32'(cnt_load), 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    chk("mrst_after_cnt", 32'(cnt_load), 0);
    chk("mrst_after_valid", 32'(out_valid), 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_instr  = gen_instr();
      type_mask = 3'($urandom);
      cnt_clr   = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 199) == 0);
      cyc();
    end
    rst = 1'b0; in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
